// File: rtl/dma_ram_rd_demux_seg.sv
// dma_ram_rd_demux_seg: one segment of the RAM read demultiplexer.
//   Routes one control-side read command stream to one of PORTS RAM-side
//   ports (the upper select bits choose the port). It returns the read data
//   strictly in command order, using a small FIFO of port indices.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_sel/addr/valid/ready     control-side command
//   resp_data/valid/ready        control-side response
//   ram_cmd_sel/addr             command fields, shared by every RAM port
//   ram_cmd_valid/ready          per-port command handshake
//   ram_resp_data/valid/ready    per-port response (data packed port-major)
// Build option: DMA_RAM_RD_DEMUX_RESP_REG_EN registers the response path
//   through a 2-entry skid buffer (1 cycle latency, full throughput).
module dma_ram_rd_demux_seg #(
  parameter int PORTS           = 2,
  parameter int SEG_DATA_WIDTH  = 64,
  parameter int SEG_ADDR_WIDTH  = 8,
  parameter int S_RAM_SEL_WIDTH = 2,
  parameter int M_RAM_SEL_WIDTH = S_RAM_SEL_WIDTH + $clog2(PORTS),
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [M_RAM_SEL_WIDTH-1:0]  cmd_sel,
  input  logic [SEG_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  output logic [SEG_DATA_WIDTH-1:0]   resp_data,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [S_RAM_SEL_WIDTH-1:0]  ram_cmd_sel,
  output logic [SEG_ADDR_WIDTH-1:0]   ram_cmd_addr,
  output logic [PORTS-1:0]            ram_cmd_valid,
  input  logic [PORTS-1:0]            ram_cmd_ready,
  input  logic [PORTS*SEG_DATA_WIDTH-1:0] ram_resp_data,
  input  logic [PORTS-1:0]            ram_resp_valid,
  output logic [PORTS-1:0]            ram_resp_ready
);

  localparam int IDX_W = (M_RAM_SEL_WIDTH > S_RAM_SEL_WIDTH) ?
                         (M_RAM_SEL_WIDTH - S_RAM_SEL_WIDTH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] port_idx;
  logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] head;
  logic             fifo_full, fifo_empty, idx_ok, sel_ram_ready;
  logic             push, pop, take, head_valid;
  logic [SEG_DATA_WIDTH-1:0] head_data;

  if (PORTS > 1 && M_RAM_SEL_WIDTH > S_RAM_SEL_WIDTH) begin : g_idx
    assign port_idx = cmd_sel[M_RAM_SEL_WIDTH-1:S_RAM_SEL_WIDTH];
  end else begin : g_idx_zero
    assign port_idx = '0;
  end

  assign ram_cmd_sel  = cmd_sel[S_RAM_SEL_WIDTH-1:0];
  assign ram_cmd_addr = cmd_addr;
  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count == '0);
  assign head         = fifo_mem[rd_ptr];

  // Command routing. Outputs are gated by rst_n so that valids/readies are
  // low for the whole reset period, not just after the first clock.
  always_comb begin
    idx_ok        = int'(port_idx) < PORTS;
    sel_ram_ready = 1'b0;
    ram_cmd_valid = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (int'(port_idx) == p) begin
        sel_ram_ready    = ram_cmd_ready[p];
        ram_cmd_valid[p] = rst_n && cmd_valid && !fifo_full;
      end
    end
    cmd_ready = rst_n && idx_ok && !fifo_full && sel_ram_ready;
  end

  assign push = cmd_valid && cmd_ready;

  // Response routing: only the port at the FIFO head may hand over data.
  always_comb begin
    head_valid     = 1'b0;
    head_data      = '0;
    ram_resp_ready = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (int'(head) == p) begin
        head_valid        = ram_resp_valid[p];
        head_data         = ram_resp_data[p*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
        ram_resp_ready[p] = take && !fifo_empty;
      end
    end
  end

  assign pop = !fifo_empty && head_valid && take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= port_idx;
  end

`ifdef DMA_RAM_RD_DEMUX_RESP_REG_EN
  // Skid space depends only on registered occupancy, so ram_resp_ready has
  // no combinational path from resp_ready.
  logic [SEG_DATA_WIDTH-1:0] skid_data [2];
  logic       skid_wr, skid_rd, out_hs;
  logic [1:0] skid_cnt;

  assign take       = (skid_cnt != 2'd2);
  assign resp_valid = (skid_cnt != 2'd0);
  assign resp_data  = skid_data[skid_rd];
  assign out_hs     = resp_valid && resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_wr      <= 1'b0;
      skid_rd      <= 1'b0;
      skid_cnt     <= 2'd0;
      skid_data[0] <= '0;
      skid_data[1] <= '0;
    end else begin
      if (pop) begin
        skid_data[skid_wr] <= head_data;
        skid_wr            <= ~skid_wr;
      end
      if (out_hs) skid_rd <= ~skid_rd;
      case ({pop, out_hs})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: ;
      endcase
    end
  end
`else
  assign take       = resp_ready;
  assign resp_valid = !fifo_empty && head_valid;
  assign resp_data  = head_data;
`endif

endmodule

// File: rtl/dma_ram_rd_demux.sv
// dma_ram_rd_demux: splits a segmented RAM read interface across PORTS
//   RAM-side ports. Each segment is independent (dma_ram_rd_demux_seg).
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   ctrl_rd_cmd_sel/addr/valid/ready    control-side commands, per segment
//   ctrl_rd_resp_data/valid/ready       control-side responses, per segment
//   ram_rd_cmd_sel/addr/valid/ready     RAM-side commands, port-major
//   ram_rd_resp_data/valid/ready        RAM-side responses, port-major
//   Port-major: entry for port p, segment s sits at index p*SEG_COUNT+s.
// Build option: DMA_RAM_RD_DEMUX_RESP_REG_EN adds a registered response
//   path (1 cycle latency) in every segment.
module dma_ram_rd_demux #(
  parameter int PORTS           = 2,
  parameter int SEG_COUNT       = 2,
  parameter int SEG_DATA_WIDTH  = 64,
  parameter int SEG_ADDR_WIDTH  = 8,
  parameter int S_RAM_SEL_WIDTH = 2,
  parameter int M_RAM_SEL_WIDTH = S_RAM_SEL_WIDTH + $clog2(PORTS),
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [SEG_COUNT*M_RAM_SEL_WIDTH-1:0]        ctrl_rd_cmd_sel,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]         ctrl_rd_cmd_addr,
  input  logic [SEG_COUNT-1:0]                        ctrl_rd_cmd_valid,
  output logic [SEG_COUNT-1:0]                        ctrl_rd_cmd_ready,
  output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]         ctrl_rd_resp_data,
  output logic [SEG_COUNT-1:0]                        ctrl_rd_resp_valid,
  input  logic [SEG_COUNT-1:0]                        ctrl_rd_resp_ready,
  output logic [PORTS*SEG_COUNT*S_RAM_SEL_WIDTH-1:0]  ram_rd_cmd_sel,
  output logic [PORTS*SEG_COUNT*SEG_ADDR_WIDTH-1:0]   ram_rd_cmd_addr,
  output logic [PORTS*SEG_COUNT-1:0]                  ram_rd_cmd_valid,
  input  logic [PORTS*SEG_COUNT-1:0]                  ram_rd_cmd_ready,
  input  logic [PORTS*SEG_COUNT*SEG_DATA_WIDTH-1:0]   ram_rd_resp_data,
  input  logic [PORTS*SEG_COUNT-1:0]                  ram_rd_resp_valid,
  output logic [PORTS*SEG_COUNT-1:0]                  ram_rd_resp_ready
);

  for (genvar s = 0; s < SEG_COUNT; s++) begin : g_seg
    logic [S_RAM_SEL_WIDTH-1:0]      seg_sel;
    logic [SEG_ADDR_WIDTH-1:0]       seg_addr;
    logic [PORTS-1:0]                seg_cmd_valid, seg_cmd_ready;
    logic [PORTS-1:0]                seg_resp_valid, seg_resp_ready;
    logic [PORTS*SEG_DATA_WIDTH-1:0] seg_resp_data;

    for (genvar p = 0; p < PORTS; p++) begin : g_port
      localparam int IDX = p*SEG_COUNT + s;
      assign ram_rd_cmd_sel[IDX*S_RAM_SEL_WIDTH +: S_RAM_SEL_WIDTH] = seg_sel;
      assign ram_rd_cmd_addr[IDX*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]  = seg_addr;
      assign ram_rd_cmd_valid[IDX]  = seg_cmd_valid[p];
      assign seg_cmd_ready[p]       = ram_rd_cmd_ready[IDX];
      assign seg_resp_data[p*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] =
        ram_rd_resp_data[IDX*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
      assign seg_resp_valid[p]      = ram_rd_resp_valid[IDX];
      assign ram_rd_resp_ready[IDX] = seg_resp_ready[p];
    end

    dma_ram_rd_demux_seg #(
      .PORTS          (PORTS),
      .SEG_DATA_WIDTH (SEG_DATA_WIDTH),
      .SEG_ADDR_WIDTH (SEG_ADDR_WIDTH),
      .S_RAM_SEL_WIDTH(S_RAM_SEL_WIDTH),
      .M_RAM_SEL_WIDTH(M_RAM_SEL_WIDTH),
      .FIFO_DEPTH     (FIFO_DEPTH)
    ) u_seg (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_sel       (ctrl_rd_cmd_sel[s*M_RAM_SEL_WIDTH +: M_RAM_SEL_WIDTH]),
      .cmd_addr      (ctrl_rd_cmd_addr[s*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
      .cmd_valid     (ctrl_rd_cmd_valid[s]),
      .cmd_ready     (ctrl_rd_cmd_ready[s]),
      .resp_data     (ctrl_rd_resp_data[s*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
      .resp_valid    (ctrl_rd_resp_valid[s]),
      .resp_ready    (ctrl_rd_resp_ready[s]),
      .ram_cmd_sel   (seg_sel),
      .ram_cmd_addr  (seg_addr),
      .ram_cmd_valid (seg_cmd_valid),
      .ram_cmd_ready (seg_cmd_ready),
      .ram_resp_data (seg_resp_data),
      .ram_resp_valid(seg_resp_valid),
      .ram_resp_ready(seg_resp_ready)
    );
  end

endmodule
